uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter: serialises one parallel word per frame onto the `tx` line, LSB first.
- Frame: start bit (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1).
- Bit timing comes from an internal baud counter. Its divisor is FRE/BAUD_RATE, the same as the receive-side baud generator, so both ends of the link agree on bit period.
- Sits between the system-side producer (valid/ready handshake) and the TX pad.

Parameters:
- FRE, 40_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- COUNT_MAX, FRE/BAUD_RATE, clocks per bit (must be >= 2)
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY_EN, 0, 1 = append parity bit after data
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- tx_data  input  DATA_BITS  word to transmit; sampled only on accept
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept a word (high only in IDLE)
- tx  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is in progress (START through last STOP)
- tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, immediate, also mid-frame):
  - Outputs: tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Internal state: state=IDLE, baud counter=0, bit index=0, shift register=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter:
  - Width is $clog2(COUNT_MAX).
  - Cleared on accept.
  - Counts 0..COUNT_MAX-1 in every non-IDLE state, then wraps to 0 and advances to the next bit.
  - Each bit on `tx` therefore lasts exactly COUNT_MAX clocks.
- IDLE:
  - tx=1, tx_ready=1, tx_busy=0.
  - Accept occurs at a rising edge where tx_valid=1 and tx_ready=1.
  - On accept: latch tx_data into the shift register, compute the parity bit, go to START. After that edge: tx=0, tx_ready=0, tx_busy=1.
- START: tx=0 for COUNT_MAX clocks, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit[index], starting with bit 0 (LSB first).
  - After each COUNT_MAX clocks, index increments.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY:
  - tx = ^data XOR PARITY_ODD, using the latched data.
  - Lasts COUNT_MAX clocks, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*COUNT_MAX clocks.
  - At the edge ending the last stop bit: state=IDLE, tx_ready=1, tx_busy=0, tx_done=1 for exactly one cycle.
- Back-to-back frames:
  - A word presented during tx_done's cycle is accepted at the next edge.
  - Minimum inter-frame idle is 1 clock, so the effective stop time is STOP_BITS*COUNT_MAX+1 clocks.
- tx_valid while tx_ready=0 is ignored; nothing is queued or dropped silently (the producer must hold tx_valid).
- Changes to tx_data after accept do not affect the frame in flight.
- Total frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * COUNT_MAX clocks from the first tx=0 to the tx_done pulse. Defaults: 10*4166 = 41660 clocks.
- No illegal-state lockup: any unused state encoding returns to IDLE with tx=1.

Test Plan (sim parameters FRE=1_000_000, BAUD_RATE=100_000, so COUNT_MAX=10, unless noted):
- Reset then idle, tx_valid=0 for 100 clk -> tx=1, tx_ready=1, tx_busy=0, tx_done never asserts.
- Send 0xA5, 8N1 -> tx low 10 clk, then bits 1,0,1,0,0,1,0,1 at 10 clk each, stop high 10 clk; tx_done pulses 1 clk exactly 100 clk after the start edge; a bench UART model decodes 0xA5.
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - second accept occurs the cycle after the first tx_done;
  - inter-frame tx=1 duration is 11 clk;
  - both words decode correctly; tx_data changes mid-frame do not corrupt the first word.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07:
  - parity bit = 1, two stop bits, frame = 12*10 = 120 clk;
  - with PARITY_ODD=1 the parity bit = 0.
- Assert rst for 1 clk during DATA bit 3 of 0x3C:
  - tx=1 immediately (same timestep, asynchronous), tx_ready=1, tx_busy=0, no tx_done pulse;
  - next accept of 0x3C produces a full, correct frame.
- Defaults (FRE=40_000_000, BAUD_RATE=9600), send 0x55 -> each bit measures 4166 clk; total 41660 clk to tx_done.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one DATA_BITS word per frame, LSB first, with optional
// parity and one or two stop bits. Bit period is COUNT_MAX clocks. Every
// output is a flop, so no input reaches an output combinationally.
module uart_tx #(
    parameter int FRE        = 40_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int COUNT_MAX  = FRE / BAUD_RATE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(COUNT_MAX);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COUNT_MAX - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 tx_q,       tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q,  tx_busy_d;
    logic                 tx_done_q,  tx_done_d;

    logic bit_end;

    // State and registered outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            // NOTE: the data latch is cleared on reset so a reset mid-frame leaves no stale word behind.
            shift_q    <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bit_end = (baud_cnt_q == CNT_LAST);

    // Next-state: baud counting, bit sequencing and word capture on accept.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (tx_valid && tx_ready_q) begin
                    shift_d = tx_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unused encodings fall back to an idle line.
                state_d    = S_IDLE;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they are valid right after each edge.
    always_comb begin
        tx_d       = 1'b1;
        tx_ready_d = (state_d == S_IDLE);
        tx_busy_d  = (state_d != S_IDLE);
        tx_done_d  = (state_q == S_STOP) && (state_d == S_IDLE);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_idx_d];
            S_PARITY: tx_d = (^shift_d) ^ (PARITY_ODD != 0);
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E2, 8O2 at 10 clk/bit, and the
// default 40 MHz / 9600 baud). A frame-level model predicts tx, tx_busy,
// tx_ready and tx_done every cycle; directed tests add hand-computed literals.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v;
    logic [3:0] tx_valid;
    logic [3:0] tx_w;
    logic [3:0] rdy_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;
    logic [7:0] tx_data [4];

    int checks   = 0;
    int failures = 0;

    // Per-instance line configuration used by the model.
    int cm_t   [4] = '{10, 10, 10, 4166};
    int par_t  [4] = '{0, 1, 1, 0};
    int odd_t  [4] = '{0, 0, 1, 0};
    int stop_t [4] = '{1, 2, 2, 1};

    uart_tx #(.FRE(1_000_000), .BAUD_RATE(100_000)) u_8n1 (
        .clk(clk), .rst(rst_v[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.FRE(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .rst(rst_v[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx #(.FRE(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
        .clk(clk), .rst(rst_v[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx u_dflt (
        .clk(clk), .rst(rst_v[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit         m_act  [4];
    int         m_t    [4];
    bit         m_done [4];
    logic [7:0] m_word [4];

    function automatic int frame_len(input int i);
        return (1 + 8 + par_t[i] + stop_t[i]) * cm_t[i];
    endfunction

    // Line level of bit slot k of the frame carrying m_word[i].
    function automatic logic exp_bit(input int i, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_word[i][k-1];
        if (par_t[i] != 0 && k == 9) return (^m_word[i]) ^ odd_t[i][0];
        return 1'b1;
    endfunction

    // Advance the model at each edge, then compare all instances 1 time unit later.
    initial begin
        logic [3:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_done[i] = 1'b0; m_word[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rst_v[i]) begin
                    m_act[i] = 1'b0; m_t[i] = 0; m_done[i] = 1'b0;
                end else if (!m_act[i]) begin
                    m_done[i] = 1'b0;
                    if (tx_valid[i]) begin
                        m_act[i]  = 1'b1;
                        m_t[i]    = 0;
                        m_word[i] = tx_data[i];
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == frame_len(i)) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                exp_v = {m_act[i] ? exp_bit(i, m_t[i] / cm_t[i]) : 1'b1,
                         m_act[i], !m_act[i], m_done[i]};
                check($sformatf("cycle_inst%0d_{tx,busy,ready,done}", i),
                      {28'd0, tx_w[i], busy_w[i], rdy_w[i], done_w[i]}, {28'd0, exp_v});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_word(input int i, input logic [7:0] d);
        int n;
        @(negedge clk);
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy_w[i] && n < 200000);
        check($sformatf("accept_inst%0d", i), {31'd0, busy_w[i]}, 32'd1);
        tx_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit, output int n);
        n = 0;
        while (!done_w[i] && n < limit) begin @(negedge clk); n++; end
    endtask

    // Hunt for a start bit, then sample nsamp bit slots at their midpoints.
    task automatic uart_decode(input int i, input int nsamp, output logic [11:0] bits);
        int n;
        int cm;
        cm   = cm_t[i];
        bits = '0;
        n    = 0;
        do begin @(negedge clk); n++; end while (tx_w[i] !== 1'b0 && n < 200000);
        repeat (cm / 2) @(negedge clk);
        for (int k = 0; k < nsamp; k++) begin
            bits[k] = tx_w[i];
            if (k < nsamp - 1) repeat (cm) @(negedge clk);
        end
    endtask

    task automatic run_len(input int i, output int len);
        logic v;
        v   = tx_w[i];
        len = 0;
        while (tx_w[i] === v && len < 100000) begin len++; @(negedge clk); end
    endtask

    task automatic count_done(input int i, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin @(negedge clk); if (done_w[i]) cnt++; end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          n;
        int          cnt;
        int          len;
        logic [11:0] bits_a;
        logic [11:0] bits_b;

        rst_v    = 4'hF;
        tx_valid = 4'h0;
        for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_v = 4'h0;

        // Reset state and a quiet idle period.
        @(negedge clk);
        check("reset_tx",    {31'd0, tx_w[0]},   32'd1);
        check("reset_ready", {31'd0, rdy_w[0]},  32'd1);
        check("reset_busy",  {31'd0, busy_w[0]}, 32'd0);
        check("reset_done",  {31'd0, done_w[0]}, 32'd0);
        count_done(0, 100, cnt);
        check("idle_no_done", cnt, 0);

        // 0xA5 8N1: frame 0 1010 0101 1 on the line, done 100 clk after accept.
        fork
            begin start_word(0, 8'hA5); wait_done(0, 1000, n); end
            uart_decode(0, 10, bits_a);
        join
        check("a5_done_latency", n, 100);
        check("a5_decode", {20'd0, bits_a}, 32'h34A);
        repeat (5) @(negedge clk);

        // Back-to-back 0x00 then 0xFF with tx_valid held; data changes mid-frame.
        fork
            begin
                @(negedge clk);
                tx_data[0]  = 8'h00;
                tx_valid[0] = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!busy_w[0] && n < 1000);
                repeat (20) @(negedge clk);
                tx_data[0] = 8'hFF;
                wait_done(0, 1000, n);
                @(negedge clk);
                check("b2b_second_accept_{busy,tx}", {30'd0, busy_w[0], tx_w[0]}, 32'd2);
                tx_valid[0] = 1'b0;
            end
            begin
                uart_decode(0, 10, bits_a);
                uart_decode(0, 10, bits_b);
            end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (tx_w[0] !== 1'b0 && n < 1000);
                run_len(0, len);
                run_len(0, len);
                check("b2b_gap_high", len, 11);
            end
        join
        check("b2b_first_word",  {20'd0, bits_a}, 32'h200);
        check("b2b_second_word", {20'd0, bits_b}, 32'h3FE);
        wait_done(0, 1000, n);
        repeat (5) @(negedge clk);

        // Reset pulse during data bit 3 of 0x3C, then a clean resend.
        start_word(0, 8'h3C);
        repeat (45) @(negedge clk);
        rst_v[0] = 1'b1;
        #1;
        check("midrst_tx",    {31'd0, tx_w[0]},   32'd1);
        check("midrst_ready", {31'd0, rdy_w[0]},  32'd1);
        check("midrst_busy",  {31'd0, busy_w[0]}, 32'd0);
        check("midrst_done",  {31'd0, done_w[0]}, 32'd0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        count_done(0, 80, cnt);
        check("midrst_no_done", cnt, 0);
        fork
            begin start_word(0, 8'h3C); wait_done(0, 1000, n); end
            uart_decode(0, 10, bits_a);
        join
        check("resend_done_latency", n, 100);
        check("resend_decode", {20'd0, bits_a}, 32'h278);

        // 0x07 with even parity / two stops: parity 1, 120 clk frame.
        fork
            begin start_word(1, 8'h07); wait_done(1, 1000, n); end
            uart_decode(1, 12, bits_a);
        join
        check("even_done_latency", n, 120);
        check("even_decode", {20'd0, bits_a}, 32'hE0E);

        // Same word with odd parity: parity 0.
        fork
            begin start_word(2, 8'h07); wait_done(2, 1000, n); end
            uart_decode(2, 12, bits_a);
        join
        check("odd_done_latency", n, 120);
        check("odd_decode", {20'd0, bits_a}, 32'hC0E);

        // Default rate, 0x55: every bit slot alternates level, 4166 clk each.
        fork
            begin start_word(3, 8'h55); wait_done(3, 50000, n); end
            begin
                cnt = 0;
                do begin @(negedge clk); cnt++; end while (tx_w[3] !== 1'b0 && cnt < 1000);
                for (int k = 0; k < 9; k++) begin
                    run_len(3, len);
                    check($sformatf("dflt_bit%0d_len", k), len, 4166);
                end
            end
        join
        check("dflt_done_latency", n, 41660);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
